// File: rtl/aludec_pkg.sv
// Shared encodings for the execute-stage ALU decoder and the multiply/divide engine.
package aludec_pkg;

    // ALU operation select codes driven onto alucontrol
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_NOR  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1111
    } alu_ctrl_t;

    // Instruction classes from the main decoder
    localparam logic [2:0] AOP_ADD   = 3'b000;
    localparam logic [2:0] AOP_SUB   = 3'b001;
    localparam logic [2:0] AOP_RTYPE = 3'b010;
    localparam logic [2:0] AOP_AND   = 3'b011;
    localparam logic [2:0] AOP_OR    = 3'b100;
    localparam logic [2:0] AOP_SLT   = 3'b101;
    localparam logic [2:0] AOP_XOR   = 3'b110;
    localparam logic [2:0] AOP_SLTU  = 3'b111;

    // R-type function fields
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_t;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    // True for the four multi-cycle arithmetic functions
    function automatic logic is_md_arith(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    // Map an arithmetic md function field onto the engine opcode
    function automatic md_op_t md_op_of(input logic [5:0] f);
        md_op_t op;
        case (f)
            F_MULTU: op = MD_MULTU;
            F_DIV:   op = MD_DIV;
            F_DIVU:  op = MD_DIVU;
            default: op = MD_MULT;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/aludec_md_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider working on operand
// magnitudes, with sign fix-up applied to the final step's result.
module muldiv_core
    import aludec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  md_op_t           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             active_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q, neg_q, rneg_q, dz_q;
    logic [WIDTH-1:0] opnd_q, acc_q, lo_q, araw_q;
    logic [WIDTH-1:0] acc_d, lo_d;

    logic             signed_op, div_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, addend, diff, quo, rem;
    logic [WIDTH:0]   sum, shifted;
    logic             borrow;
    logic [2*WIDTH-1:0] prod, prod_f;

    assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign div_op    = (op_i == MD_DIV)  || (op_i == MD_DIVU);
    assign a_neg     = signed_op & a_i[WIDTH-1];
    assign b_neg     = signed_op & b_i[WIDTH-1];
    assign mag_a     = a_neg ? -a_i : a_i;
    assign mag_b     = b_neg ? -b_i : b_i;
    assign done_o    = active_q && (cnt_q == CW'(WIDTH - 1));
    assign addend    = lo_q[0] ? opnd_q : {WIDTH{1'b0}};

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        acc_d   = acc_q;
        lo_d    = lo_q;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        borrow  = 1'b0;
        if (is_div_q) begin
            shifted = {acc_q, lo_q[WIDTH-1]};
            diff    = shifted[WIDTH-1:0] - opnd_q;
            borrow  = shifted < {1'b0, opnd_q};
            acc_d   = borrow ? shifted[WIDTH-1:0] : diff;
            lo_d    = {lo_q[WIDTH-2:0], ~borrow};
        end else begin
            sum   = {1'b0, acc_q} + {1'b0, addend};
            acc_d = sum[WIDTH:1];
            lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the step result; divide-by-zero bypasses the datapath
    always_comb begin
        prod   = {acc_d, lo_d};
        prod_f = neg_q ? -prod : prod;
        quo    = neg_q ? -lo_d : lo_d;
        rem    = rneg_q ? -acc_d : acc_d;
        if (!is_div_q) begin
            hi_o = prod_f[2*WIDTH-1:WIDTH];
            lo_o = prod_f[WIDTH-1:0];
        end else if (dz_q) begin
            hi_o = araw_q;
            lo_o = {WIDTH{1'b1}};
        end else begin
            hi_o = rem;
            lo_o = quo;
        end
    end

    // Iteration counter and activity flag; reset abandons any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
        end else if (active_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (done_o) active_q <= 1'b0;
        end
    end

    // Operand capture at start, accumulator update each active cycle
    always_ff @(posedge clk) begin
        if (start_i) begin
            is_div_q <= div_op;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            dz_q     <= div_op & (b_i == '0);
            araw_q   <= a_i;
            acc_q    <= '0;
            opnd_q   <= div_op ? mag_b : mag_a;
            lo_q     <= div_op ? mag_a : mag_b;
        end else if (active_q) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: rtl/aludec_md.sv
// Execute-stage ALU decoder with multi-cycle multiply/divide sequencing
// and the architectural HI/LO registers.
module aludec_md
    import aludec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [3:0]       alucontrol,
    output logic             busy,
    output logic             res_sel,
    output logic [WIDTH-1:0] mdresult,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    alu_ctrl_t        ctrl;
    logic             is_r, launch, core_done;
    logic [WIDTH-1:0] core_hi, core_lo;

    assign is_r       = (aluop == AOP_RTYPE);
    assign launch     = en & is_r & is_md_arith(funct) & (state_q == MD_IDLE);
    assign busy       = launch | (state_q == MD_RUN);
    assign res_sel    = en & is_r & ((funct == F_MFHI) || (funct == F_MFLO));
    assign mdresult   = (funct == F_MFHI) ? hi_q : lo_q;
    assign alucontrol = ctrl;
    assign hi         = hi_q;
    assign lo         = lo_q;

    // ALU operation decode, independent of the md sequencer
    always_comb begin
        ctrl = ALU_AND;
        case (aluop)
            AOP_ADD:  ctrl = ALU_ADD;
            AOP_SUB:  ctrl = ALU_SUB;
            AOP_AND:  ctrl = ALU_AND;
            AOP_OR:   ctrl = ALU_OR;
            AOP_SLT:  ctrl = ALU_SLT;
            AOP_XOR:  ctrl = ALU_XOR;
            AOP_SLTU: ctrl = ALU_SLTU;
            AOP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: ctrl = ALU_ADD;
                    F_SUB, F_SUBU: ctrl = ALU_SUB;
                    F_AND:         ctrl = ALU_AND;
                    F_OR:          ctrl = ALU_OR;
                    F_XOR:         ctrl = ALU_XOR;
                    F_NOR:         ctrl = ALU_NOR;
                    F_SLT:         ctrl = ALU_SLT;
                    F_SLTU:        ctrl = ALU_SLTU;
                    default:       ctrl = ALU_AND;
                endcase
            end
            default: ctrl = ALU_AND;
        endcase
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (reset),
        .start_i (launch),
        .op_i    (md_op_of(funct)),
        .a_i     (srca),
        .b_i     (srcb),
        .done_o  (core_done),
        .hi_o    (core_hi),
        .lo_o    (core_lo)
    );

    // md sequencer: launch, wait for the engine, commit HI/LO; mthi/mtlo in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (launch) begin
                        state_q <= MD_RUN;
                    end else if (en && is_r && funct == F_MTHI) begin
                        hi_q <= srca;
                    end else if (en && is_r && funct == F_MTLO) begin
                        lo_q <= srca;
                    end
                end
                MD_RUN: begin
                    if (core_done) begin
                        state_q <= MD_DONE;
                        hi_q    <= core_hi;
                        lo_q    <= core_lo;
                    end
                end
                // The launching instruction is still in execute here, so
                // any md op seen this cycle is that same instruction.
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aludec_md.sv
// Self-checking bench for aludec_md: directed decode/mthi/mtlo/reset steps
// plus randomized multiply/divide against an arithmetic reference model.
module tb_aludec_md;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;

    logic        clk, reset, en;
    logic [2:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] srca, srcb;
    logic [3:0]  alucontrol;
    logic        busy, res_sel;
    logic [31:0] mdresult, hi, lo;

    int checks = 0;
    int errors = 0;

    aludec_md #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .aluop      (aluop),
        .funct      (funct),
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (alucontrol),
        .busy       (busy),
        .res_sel    (res_sel),
        .mdresult   (mdresult),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference {HI,LO} from plain arithmetic on the architectural rules
    function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        int sa, sb;
        logic [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r = p;
            end
            MULTU: r = {32'b0, a} * {32'b0, b};
            DIV: begin
                if (b == 32'd0)                                r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
                else                                           r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic chk_dec(input logic [2:0] a, input logic [5:0] f, input logic [3:0] e);
        en = 1'b1; aluop = a; funct = f;
        #1;
        check("alucontrol", alucontrol, e);
        check("dec_busy", busy, 1'b0);
    endtask

    // Launch one md op, count busy cycles, then check HI/LO, DONE-cycle
    // blocking of a repeated op, and a dependent mfhi/mflo.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        logic [63:0] exp;
        exp = ref_md(f, a, b);
        cnt = 0;
        @(posedge clk); #1;
        en = 1'b1; aluop = 3'b010; funct = f; srca = a; srcb = b;
        #1;
        while (busy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
            en = 1'b0;
            #1;
        end
        check({tag, "_busy_cycles"}, cnt, 33);
        check({tag, "_hi"}, hi, exp[63:32]);
        check({tag, "_lo"}, lo, exp[31:0]);
        en = 1'b1; funct = f;
        #1;
        check({tag, "_done_ignore"}, busy, 1'b0);
        @(posedge clk); #1;
        funct = MFHI; srca = 32'd0;
        #1;
        check({tag, "_mfhi_sel"}, res_sel, 1'b1);
        check({tag, "_mfhi"}, mdresult, exp[63:32]);
        funct = MFLO;
        #1;
        check({tag, "_mflo"}, mdresult, exp[31:0]);
        en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; aluop = 3'b000; funct = 6'b0; srca = 32'd0; srcb = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;

        // ALU decode table
        chk_dec(3'b010, 6'b100111, 4'b0100);
        chk_dec(3'b111, 6'b000000, 4'b1111);
        chk_dec(3'b010, 6'b111111, 4'b0000);
        chk_dec(3'b000, 6'b011000, 4'b0010);
        chk_dec(3'b001, 6'b000000, 4'b0110);
        chk_dec(3'b011, 6'b000000, 4'b0000);
        chk_dec(3'b100, 6'b000000, 4'b0001);
        chk_dec(3'b101, 6'b000000, 4'b0111);
        chk_dec(3'b110, 6'b000000, 4'b0011);
        chk_dec(3'b010, 6'b100001, 4'b0010);
        chk_dec(3'b010, 6'b100011, 4'b0110);
        chk_dec(3'b010, 6'b100100, 4'b0000);
        chk_dec(3'b010, 6'b100101, 4'b0001);
        chk_dec(3'b010, 6'b100110, 4'b0011);
        chk_dec(3'b010, 6'b101010, 4'b0111);
        chk_dec(3'b010, 6'b101011, 4'b1111);

        // mthi/mtlo then mfhi/mflo
        @(posedge clk); #1;
        en = 1'b1; aluop = 3'b010; funct = MTHI; srca = 32'h1234;
        @(posedge clk); #1;
        funct = MFHI; srca = 32'd0;
        #1;
        check("mfhi_sel", res_sel, 1'b1);
        check("mfhi_val", mdresult, 32'h1234);
        check("mthi_hi", hi, 32'h1234);
        funct = MTLO; srca = 32'hCAFE;
        @(posedge clk); #1;
        funct = MFLO; srca = 32'd0;
        #1;
        check("mflo_sel", res_sel, 1'b1);
        check("mflo_val", mdresult, 32'hCAFE);
        en = 1'b0; funct = MTHI; srca = 32'h5555;
        @(posedge clk); #1;
        check("mthi_no_en", hi, 32'h1234);
        check("mfhi_no_en_sel", res_sel, 1'b0);

        // md op with en low never launches
        funct = MULT; srca = 32'd3; srcb = 32'd4;
        #1;
        check("no_en_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("no_en_busy_next", busy, 1'b0);

        // Directed md operations
        run_md("mult_neg", MULT, 32'hFFFFFFFD, 32'd7);
        run_md("divu", DIVU, 32'd100, 32'd7);
        run_md("div_neg", DIV, 32'hFFFFFFF9, 32'd2);
        run_md("divu_zero", DIVU, 32'd5, 32'd0);
        run_md("div_zero", DIV, 32'hFFFFFFFB, 32'd0);
        run_md("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF);
        run_md("multu_big", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Randomized md operations
        for (int i = 0; i < 12; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
                0:       f = MULT;
                1:       f = MULTU;
                2:       f = DIV;
                default: f = DIVU;
            endcase
            a = $urandom;
            b = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom;
            run_md("rand", f, a, b);
        end

        // Reset during RUN discards the operation and clears HI/LO at once
        @(posedge clk); #1;
        en = 1'b1; aluop = 3'b010; funct = MTLO; srca = 32'hA5A5;
        @(posedge clk); #1;
        funct = MULTU; srca = 32'h12345678; srcb = 32'h9ABCDEF0;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("run10_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_busy", busy, 1'b0);
        run_md("multu_after_rst", MULTU, 32'd6, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
